// File: rtl/zeroskip_stream_packer.sv
// Zero-skip activation compactor: packs each row's non-zero activations into
// per-beat slot fields and merges 1, 2 or 4 beats into one output word.
module zeroskip_stream_packer #(
  parameter int M          = 32,
  parameter int GROUP_SIZE = 32,
  parameter int DATA_W     = 8,
  parameter int OUT_SLOTS  = GROUP_SIZE / 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [1:0]                        mode_i,
  input  logic                              in_vld_i,
  output logic                              in_rdy_o,
  input  logic                              in_last_i,
  input  logic [GROUP_SIZE*DATA_W-1:0]      act_i,
  input  logic [M*GROUP_SIZE-1:0]           znz_i,
  output logic                              out_vld_o,
  input  logic                              out_rdy_i,
  output logic [M*OUT_SLOTS*DATA_W-1:0]     out_dout_o,
  output logic [2:0]                        out_beats_o,
  output logic                              err_ovf_o
);

  localparam int ROW_W  = OUT_SLOTS * DATA_W;
  localparam int WORD_W = M * ROW_W;

  localparam logic [1:0] MODE_1_2  = 2'd0;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  logic [1:0]        beat_cnt_reg, beat_cnt_next;
  logic [1:0]        mode_reg, mode_next;
  logic [WORD_W-1:0] acc_reg, acc_next;
  logic [WORD_W-1:0] dout_reg, dout_next;
  logic [2:0]        beats_reg, beats_next;
  logic              out_vld_reg, out_vld_next;
  logic              err_reg, err_next;

  logic [1:0]        mode_eff;
  int                cap_sel;
  int                base_sel;
  int                last_beat;
  logic [WORD_W-1:0] beat_word;
  logic [WORD_W-1:0] merged_word;
  logic [M-1:0]      row_ovf;
  logic              accept;
  logic              frame_done;

  // The first beat of a frame takes mode from the port; later beats use the latched copy.
  always_comb begin
    mode_eff = mode_reg;
    if (beat_cnt_reg == 2'd0) begin
      mode_eff = (mode_i == MODE_RSVD) ? MODE_1_2 : mode_i;
    end
    cap_sel   = GROUP_SIZE >> (int'(mode_eff) + 1);
    last_beat = (1 << mode_eff) - 1;
    base_sel  = int'(beat_cnt_reg) * cap_sel;
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    logic [ROW_W-1:0] row_slots;
    logic             row_over;

    // Lowest-index non-zeros win; anything past capacity is dropped.
    always_comb begin
      int cnt;
      row_slots = '0;
      cnt       = 0;
      for (int k = 0; k < GROUP_SIZE; k++) begin
        if (znz_i[gi*GROUP_SIZE + k]) begin
          if (cnt < cap_sel) begin
            row_slots[(base_sel + cnt)*DATA_W +: DATA_W] = act_i[k*DATA_W +: DATA_W];
          end
          cnt = cnt + 1;
        end
      end
      row_over = (cnt > cap_sel);
    end

    assign beat_word[gi*ROW_W +: ROW_W] = row_slots;
    assign row_ovf[gi]                  = row_over;
  end

  assign in_rdy_o    = !rst && (!out_vld_reg || out_rdy_i);
  assign accept      = in_vld_i && in_rdy_o;
  assign frame_done  = accept && ((int'(beat_cnt_reg) == last_beat) || in_last_i);
  assign merged_word = acc_reg | beat_word;

  always_comb begin
    beat_cnt_next = beat_cnt_reg;
    mode_next     = mode_reg;
    acc_next      = acc_reg;
    dout_next     = dout_reg;
    beats_next    = beats_reg;
    out_vld_next  = out_vld_reg;
    err_next      = err_reg | (accept & (|row_ovf));

    if (accept) begin
      if (beat_cnt_reg == 2'd0) begin
        mode_next = mode_eff;
      end
      if (frame_done) begin
        dout_next     = merged_word;
        beats_next    = {1'b0, beat_cnt_reg} + 3'd1;
        out_vld_next  = 1'b1;
        beat_cnt_next = 2'd0;
        acc_next      = '0;
      end else begin
        acc_next      = merged_word;
        beat_cnt_next = beat_cnt_reg + 2'd1;
      end
    end

    // A completing beat in the same cycle as the consumer's ready keeps valid high.
    if (!frame_done && out_rdy_i) begin
      out_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_reg <= 2'd0;
      mode_reg     <= 2'd0;
      acc_reg      <= '0;
      dout_reg     <= '0;
      beats_reg    <= 3'd0;
      out_vld_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      beat_cnt_reg <= beat_cnt_next;
      mode_reg     <= mode_next;
      acc_reg      <= acc_next;
      dout_reg     <= dout_next;
      beats_reg    <= beats_next;
      out_vld_reg  <= out_vld_next;
      err_reg      <= err_next;
    end
  end

  assign out_vld_o   = out_vld_reg;
  assign out_dout_o  = dout_reg;
  assign out_beats_o = beats_reg;
  assign err_ovf_o   = err_reg;

endmodule

// File: tb/tb_zeroskip_stream_packer.sv
// Scoreboard bench for zeroskip_stream_packer: a queue-based reference model
// predicts each output word; an independent monitor checks what the DUT presents.
module tb_zeroskip_stream_packer;

  localparam int M  = 32;
  localparam int G  = 32;
  localparam int DW = 8;
  localparam int OS = G / 2;
  localparam int W  = M * OS * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mode = 2'd0;
  logic            in_vld = 1'b0;
  logic            in_last = 1'b0;
  logic            out_rdy = 1'b0;
  logic [G*DW-1:0] act = '0;
  logic [M*G-1:0]  znz = '0;
  logic            in_rdy;
  logic            out_vld;
  logic [W-1:0]    out_dout;
  logic [2:0]      out_beats;
  logic            err_ovf;

  always #5 clk = ~clk;

  zeroskip_stream_packer #(.M(M), .GROUP_SIZE(G), .DATA_W(DW), .OUT_SLOTS(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_i     (mode),
    .in_vld_i   (in_vld),
    .in_rdy_o   (in_rdy),
    .in_last_i  (in_last),
    .act_i      (act),
    .znz_i      (znz),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .out_dout_o (out_dout),
    .out_beats_o(out_beats),
    .err_ovf_o  (err_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  logic [W-1:0] exp_dout_q[$];
  logic [2:0]   exp_beats_q[$];

  // Reference model state
  logic [7:0] m_acc[M][OS];
  int         m_b;
  int         m_mode;
  bit         m_err;
  bit         m_pending;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] got, input logic [W-1:0] want,
                          input logic [2:0] gb, input logic [2:0] wb);
    int bad;
    n_checks++;
    if (got !== want || gb !== wb) begin
      n_fail++;
      bad = 0;
      for (int i = 0; i < M*OS; i++) begin
        if (got[i*DW +: DW] !== want[i*DW +: DW]) begin
          bad = i;
          break;
        end
      end
      $display("FAIL %s: beats got %0d expected %0d; row %0d slot %0d got %0h expected %0h",
               name, gb, wb, bad / OS, bad % OS, got[bad*DW +: DW], want[bad*DW +: DW]);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < M; r++)
      for (int s = 0; s < OS; s++)
        m_acc[r][s] = 8'd0;
    m_b       = 0;
    m_mode    = 0;
    m_err     = 1'b0;
    m_pending = 1'b0;
    exp_dout_q.delete();
    exp_beats_q.delete();
  endtask

  // One accepted beat: list each row's non-zeros, keep the first CAP of them.
  task automatic model_beat();
    int cap;
    int nb;
    logic [7:0] nz[$];
    logic [W-1:0] word;
    if (m_b == 0) m_mode = (mode == 2'd3) ? 0 : int'(mode);
    cap = G >> (m_mode + 1);
    nb  = 1 << m_mode;
    for (int r = 0; r < M; r++) begin
      nz.delete();
      for (int k = 0; k < G; k++)
        if (znz[r*G + k]) nz.push_back(act[k*DW +: DW]);
      if (nz.size() > cap) m_err = 1'b1;
      for (int j = 0; j < cap && j < nz.size(); j++)
        m_acc[r][m_b*cap + j] = nz[j];
    end
    if (m_b == nb - 1 || in_last) begin
      word = '0;
      for (int r = 0; r < M; r++)
        for (int s = 0; s < OS; s++) begin
          word[(r*OS + s)*DW +: DW] = m_acc[r][s];
          m_acc[r][s] = 8'd0;
        end
      exp_dout_q.push_back(word);
      exp_beats_q.push_back(3'(m_b + 1));
      m_b       = 0;
      m_pending = 1'b1;
    end else begin
      m_b++;
      if (out_rdy) m_pending = 1'b0;
    end
  endtask

  // Inputs are already set; check handshake state at the falling edge, then advance.
  task automatic tick();
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = !rst && (!m_pending || out_rdy);
    chk("in_rdy", in_rdy, exp_rdy);
    chk("out_vld", out_vld, m_pending);
    chk("err_ovf", err_ovf, m_err);
    if (rst) model_reset();
    else if (in_vld && exp_rdy) model_beat();
    else if (out_rdy) m_pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input logic [31:0] mask);
    for (int r = 0; r < M; r++) znz[r*G +: G] = mask;
  endtask

  // Monitor: compares presented words against the scoreboard and checks hold stability.
  logic         p_hold = 1'b0;
  logic [W-1:0] p_dout;
  logic [2:0]   p_beats;
  logic [W-1:0] mon_exp;
  logic [2:0]   mon_eb;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && p_hold) begin
        chk("hold_vld", out_vld, 1);
        chk_word("hold_data", out_dout, p_dout, out_beats, p_beats);
      end
      p_hold  = !rst && out_vld && !out_rdy;
      p_dout  = out_dout;
      p_beats = out_beats;
      if (!rst && out_vld && out_rdy) begin
        if (exp_dout_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_exp = exp_dout_q.pop_front();
          mon_eb  = exp_beats_q.pop_front();
          chk_word("out_word", out_dout, mon_exp, out_beats, mon_eb);
          n_txn++;
          $display("txn %0d: beats=%0d row0 slots0..3=%0h %0h %0h %0h", n_txn, out_beats,
                   out_dout[7:0], out_dout[15:8], out_dout[23:16], out_dout[31:24]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int k = 0; k < G; k++) act[k*DW +: DW] = 8'(k + 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dout", (|out_dout), 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_err_ovf", err_ovf, 0);
    rst = 1'b0;
    #1;
    chk("in_rdy_after_rst", in_rdy, 1);

    // Mode 0: each row keeps elements 0..15
    mode = 2'd0; set_rows(32'h0000FFFF); out_rdy = 1'b1; in_vld = 1'b1;
    tick();
    in_vld = 1'b0; tick();

    // Mode 1: two beats on row 0
    mode = 2'd1; znz = '0; znz[31:0] = 32'h80000001; in_vld = 1'b1;
    tick();
    znz[31:0] = 32'h00000006; tick();
    in_vld = 1'b0; tick(); tick();

    // Mode 2, early flush on beat 2, then a fresh frame
    mode = 2'd2; znz = '0; znz[5*G +: G] = 32'h00000001; in_vld = 1'b1;
    tick(); tick();
    in_last = 1'b1; tick();
    in_last = 1'b1; znz[5*G +: G] = 32'h00000003; tick();
    in_last = 1'b0; in_vld = 1'b0; tick();

    // Mode 2 overflow: 9 non-zeros against capacity 4
    znz = '0; znz[31:0] = 32'h000001FF; in_vld = 1'b1;
    repeat (4) tick();
    in_vld = 1'b0; znz = '0; repeat (3) tick();

    // Back-pressure with a reload in the same cycle as the release
    mode = 2'd0; set_rows(32'h0000F0F0); in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0; set_rows(32'h12345678);
    repeat (3) tick();
    out_rdy = 1'b1; tick();
    in_vld = 1'b0; tick();

    // Reset in the middle of a mode-1 frame
    mode = 2'd1; set_rows(32'h00FF00FF); in_vld = 1'b1;
    tick();
    rst = 1'b1; in_vld = 1'b0; tick();
    rst = 1'b0;
    set_rows(32'hA5A5A5A5); in_vld = 1'b1; tick();
    set_rows(32'h0F0F0F0F); tick();
    in_vld = 1'b0; tick(); tick();

    // Randomized traffic, including mid-frame mode changes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_vld  = ($urandom_range(0, 9) < 8);
      in_last = ($urandom_range(0, 6) == 0);
      mode    = 2'($urandom_range(0, 3));
      out_rdy = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < G; k++) act[k*DW +: DW] = 8'($urandom);
      for (int r = 0; r < M; r++) begin
        case ($urandom_range(0, 3))
          0: znz[r*G +: G] = $urandom & $urandom & $urandom;
          1: znz[r*G +: G] = $urandom & $urandom;
          2: znz[r*G +: G] = $urandom;
          default: znz[r*G +: G] = $urandom | $urandom;
        endcase
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      rst = 1'b0;
    end

    in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
    repeat (4) tick();
    chk("scoreboard_empty", exp_dout_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroskip_stream_packer.md
# zeroskip_stream_packer

Streaming zero-skip compactor for the MAC array activation path: per input beat it takes one shared activation vector and M per-row zero/non-zero masks and compacts each row's selected bytes into a fixed-capacity slot field. Sparsity mode 1:2, 1:4 or 1:8 sets slot capacity per beat and how many beats merge into one M x GROUP_SIZE/2 output word. It sits between the activation/mask fetch and the MAC1K operand register. It adds valid/ready back-pressure, partial-frame flush and overflow detection, and the array width is configurable.

## Interface
- M, 32, rows (output groups); one mask per row
- GROUP_SIZE, 32, activations per input beat; power of two, >= 16
- DATA_W, 8, activation width in bits
- OUT_SLOTS, GROUP_SIZE/2, derived; slots per output row
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- mode_i  in  2  0 = 1:2, 1 = 1:4, 2 = 1:8, 3 = treated as 0
- in_vld_i  in  1  input beat valid
- in_rdy_o  out  1  input beat ready
- in_last_i  in  1  beat closes current frame early (flush)
- act_i  in  GROUP_SIZE*DATA_W  shared activations; byte k = element k
- znz_i  in  M*GROUP_SIZE  row r mask = bits [r*GROUP_SIZE +: GROUP_SIZE]; 1 = non-zero
- out_vld_o  out  1  output word valid
- out_rdy_i  in  1  output word accepted
- out_dout_o  out  M*OUT_SLOTS*DATA_W  row r slot s = byte (r*OUT_SLOTS + s)
- out_beats_o  out  3  input beats merged into current output word (1..4)
- err_ovf_o  out  1  sticky: some row had more non-zeros than capacity

## Operation
- Accepted beat: in_vld_i && in_rdy_o. in_rdy_o = !out_vld_o || out_rdy_i, and is 0 while rst is high.
- Mode is sampled on the first beat of a frame (beat counter = 0) and held until the frame ends. Changes of mode_i mid-frame are ignored.
- Mode m sets two values:
  - CAP = GROUP_SIZE >> (m+1)
  - BEATS = 1 << m
- Per row, per beat:
  - The set mask bits are scanned from index 0 upward.
  - The j-th non-zero activation goes to slot b*CAP + j, where b is the beat index within the frame (0..BEATS-1).
  - Unused slots hold 0.
- Overflow: a row with popcount > CAP keeps its first CAP non-zeros (lowest indices). The rest are dropped and err_ovf_o is set. err_ovf_o clears only on rst.
- Beat counter increments per accepted beat. A frame completes when either:
  - counter = BEATS-1, or
  - in_last_i is high on an accepted beat.
- On frame completion:
  - The accumulator, with the current beat merged in, loads out_dout_o.
  - out_beats_o = b+1.
  - out_vld_o is set.
  - The counter returns to 0 and the accumulator clears to 0.
- Partial frame: slots for beats > b are 0.
- In mode 0 every beat completes a frame; in_last_i has no extra effect.
- out_dout_o and out_beats_o hold stable while out_vld_o && !out_rdy_i.
- out_vld_o clears on out_rdy_i unless a new frame completes in that same cycle.
- Simultaneous out_rdy_i and a frame-completing beat: the output reloads and out_vld_o stays 1. No bubble, no loss.

## Timing
- Reset values (cycle after rst sampled high):
  - out_vld_o 0, out_dout_o 0, out_beats_o 0, err_ovf_o 0
  - beat counter 0, accumulator 0, latched mode 0
- in_rdy_o is 1 in the first cycle after rst drops.
- Latency: a frame-completing beat accepted in cycle t gives out_vld_o = 1 in cycle t+1.
- Throughput: one beat per cycle while out_rdy_i is held high. A mode-2 stream yields one output per 4 cycles.
- Reset mid-frame discards the partial accumulator and any pending output; no output is emitted for it.
- err_ovf_o rises in the cycle after the offending beat is accepted.
- Compaction is combinational from act_i/znz_i into the accumulator. There is no combinational path from in_vld_i to in_rdy_o.

## Test plan
Common setup: M=32, GROUP_SIZE=32, DATA_W=8, act_i byte k = k+1.
- Mode 0, all rows znz = 0x0000FFFF, out_rdy_i = 1.
  - Next cycle: out_vld_o = 1, every row's slots 0..15 = 1..16, out_beats_o = 1, err_ovf_o = 0.
- Mode 1, two beats, row 0 masks 0x80000001 then 0x00000006, out_rdy_i = 1.
  - Row 0 slots 0..1 = 1, 32; slots 8..9 = 2, 3; all other slots 0.
  - out_vld_o pulses once, after beat 2.
- Mode 2, in_last_i on beat 2, row 5 mask 0x00000001 on each beat.
  - Row 5 slots 0, 4, 8 = 1; slots 12..15 = 0; out_beats_o = 3.
  - Next frame starts at beat 0.
- Mode 2, row 0 mask 0x000001FF (9 non-zeros, CAP = 4).
  - Row 0 beat-0 slots = 1, 2, 3, 4.
  - err_ovf_o = 1 and stays 1 until rst.
- Back-pressure: mode 0, out_rdy_i low for 3 cycles with out_vld_o = 1.
  - in_rdy_o = 0 and out_dout_o stable for those 3 cycles.
  - Raise out_rdy_i together with a valid beat: the output reloads with no gap.
- Reset after beat 1 of a mode-1 frame.
  - No output is emitted; counter back to 0.
  - A fresh mode-1 frame produces correct slots 0..7 and 8..15.
